uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one UART transmitter between NREQ byte sources.
- Sits between the requesting blocks and the transmitter's Data / Data_valid / Busy interface.
- Captures the winning byte, pulses Data_valid once, and holds Data stable for the whole frame, because parity is computed from Data throughout the frame.
- Sequences one frame at a time and acknowledges the winner on completion.

---
 rtl/uart_tx_arb_pkg.sv | 22 ++
 rtl/rr_picker.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The timeout helper is only used when ARB_TIMEOUT_EN is defined.
package uart_tx_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_NREQ           = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  // Counter must hold values 0 .. cycles-1.
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches from pointer+1 upward with
// wraparound and returns the first requesting index.
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] pointer,
  output logic [IDXW-1:0] winner,
  output logic            any_req
);

  logic [IDXW-1:0] idx;

  // Scan farthest offset first so the nearest requester overwrites last.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDXW'((int'(pointer) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NREQ sources.
// Optional ARB_TIMEOUT_EN adds a Busy-rise timeout and the err_timeout flag.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = DEFAULT_NREQ
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      Tx_Data,
  output logic                  Tx_Data_valid,
  input  logic                  Tx_Busy
`ifdef ARB_TIMEOUT_EN
  , output logic                err_timeout
`endif
);

  localparam int IDXW = $clog2(NREQ);

  arb_state_t       state_reg, state_next;
  logic [IDXW-1:0]  pointer_reg;
  logic [IDXW-1:0]  winner;
  logic             any_req;
  logic [NREQ-1:0]  grant_reg;
  logic [NREQ-1:0]  ack_reg;
  logic [WIDTH-1:0] tx_data_reg;
  logic             valid_reg;
  logic             timeout_hit;
  logic [WIDTH-1:0] req_bytes [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_bytes[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req    (req),
    .pointer(pointer_reg),
    .winner (winner),
    .any_req(any_req)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  assign timeout_hit = (state_reg == WAIT_BUSY) && !Tx_Busy &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (state_reg == WAIT_BUSY && !Tx_Busy && !timeout_hit) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_timeout = err_reg;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (any_req) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (Tx_Busy) begin
          state_next = WAIT_DONE;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      // Only the first fall of Busy ends the frame.
      WAIT_DONE: if (!Tx_Busy) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered against the next state so each is visible
  // during the cycle the FSM spends in the matching state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      pointer_reg <= IDXW'(NREQ - 1);
      grant_reg   <= '0;
      ack_reg     <= '0;
      tx_data_reg <= '0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= (state_next == ISSUE);
      ack_reg   <= (state_next == DONE) ? grant_reg : '0;
      if (state_reg == IDLE && any_req) begin
        tx_data_reg <= req_bytes[winner];
        grant_reg   <= NREQ'(1) << winner;
        pointer_reg <= winner;
      end else if (state_reg == DONE) begin
        grant_reg <= '0;
      end
    end
  end

  assign grant         = grant_reg;
  assign ack           = ack_reg;
  assign Tx_Data       = tx_data_reg;
  assign Tx_Data_valid = valid_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple Busy model.
// Timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [7:0]  Tx_Data;
  logic        Tx_Data_valid;
  logic        Tx_Busy;
`ifdef ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  int total = 0;
  int bad   = 0;

  logic model_en   = 1'b0;
  int   busy_delay = 2;
  int   busy_len   = 11;

  uart_tx_arbiter dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .ack          (ack),
    .Tx_Data      (Tx_Data),
    .Tx_Data_valid(Tx_Data_valid),
    .Tx_Busy      (Tx_Busy)
`ifdef ARB_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Transmitter model: Busy rises busy_delay cycles after a valid pulse.
  initial begin
    Tx_Busy = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (model_en && Tx_Data_valid) begin
        repeat (busy_delay) begin
          @(posedge CLK);
          #1;
        end
        Tx_Busy = 1'b1;
        repeat (busy_len) begin
          @(posedge CLK);
          #1;
        end
        Tx_Busy = 1'b0;
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b1;
    req   = '0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tick();
    tick();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    total++; if (Tx_Data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", Tx_Data); end
    total++; if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", Tx_Data_valid); end
    Reset = 1'b0;
    tick();
    $display("reset done");
  endtask

  task automatic test_single();
    int valid_cnt, ack_cnt, ack_at, data_bad;
    logic [3:0] ack_val;
    valid_cnt = 0; ack_cnt = 0; ack_at = -1; data_bad = 0; ack_val = '0;
    do_reset();
    busy_delay = 2; busy_len = 11; model_en = 1'b1;
    req_data = 32'h0000_A500;
    req = 4'b0010;
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", grant); end
    total++; if (Tx_Data_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", Tx_Data_valid); end
    total++; if (Tx_Data !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", Tx_Data); end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (Tx_Data_valid) valid_cnt++;
      if (grant != 4'b0 && Tx_Data !== 8'hA5) data_bad++;
      if (ack !== 4'b0) begin
        ack_cnt++; ack_at = c; ack_val = ack; req = 4'b0;
      end
    end
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL single_extra_valid: got %0d want 0", valid_cnt); end
    total++; if (data_bad !== 0) begin bad++; $display("FAIL single_data_stable: got %0d bad cycles want 0", data_bad); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL single_ack_count: got %0d want 1", ack_cnt); end
    total++; if (ack_val !== 4'b0010) begin bad++; $display("FAIL single_ack_value: got %b want 0010", ack_val); end
    total++; if (ack_at !== 14) begin bad++; $display("FAIL single_ack_latency: got %0d want 14", ack_at); end
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
    $display("single frame: ack %b at cycle %0d", ack_val, ack_at);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack  [5];
    logic [7:0] exp_data [5];
    int n;
    exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    n = 0;
    do_reset();
    busy_delay = 1; busy_len = 3; model_en = 1'b1;
    req_data = 32'h1312_1110;
    req = 4'b1111;
    for (int c = 0; c < 200 && n < 5; c++) begin
      tick();
      if (ack !== 4'b0) begin
        total++; if (ack !== exp_ack[n]) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", n, ack, exp_ack[n]); end
        total++; if (Tx_Data !== exp_data[n]) begin bad++; $display("FAIL rr_data_%0d: got %h want %h", n, Tx_Data, exp_data[n]); end
        $display("rr frame %0d: ack %b data %h", n, ack, Tx_Data);
        n++;
        if (n == 5) req = 4'b0;
      end
    end
    total++; if (n !== 5) begin bad++; $display("FAIL rr_frames: got %0d want 5", n); end
    req = 4'b0;
    repeat (6) tick();
  endtask

  task automatic test_req_drop();
    int seen, regrants;
    logic [3:0] ack_val;
    logic [7:0] data_at_ack;
    seen = 0; regrants = 0; ack_val = '0; data_at_ack = '0;
    do_reset();
    busy_delay = 1; busy_len = 6; model_en = 1'b1;
    req_data = 32'h00C3_0000;
    req = 4'b0100;
    for (int c = 0; c < 20 && !Tx_Busy; c++) tick();
    tick();
    req = 4'b0;
    for (int c = 0; c < 30 && seen == 0; c++) begin
      tick();
      if (ack !== 4'b0) begin seen = 1; ack_val = ack; data_at_ack = Tx_Data; end
    end
    total++; if (ack_val !== 4'b0100) begin bad++; $display("FAIL drop_ack: got %b want 0100", ack_val); end
    total++; if (data_at_ack !== 8'hC3) begin bad++; $display("FAIL drop_data: got %h want c3", data_at_ack); end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant !== 4'b0) regrants++;
    end
    total++; if (regrants !== 0) begin bad++; $display("FAIL drop_regrant: got %0d grant cycles want 0", regrants); end
    $display("req drop: ack %b data %h", ack_val, data_at_ack);
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    do_reset();
    busy_delay = 1; busy_len = 8; model_en = 1'b1;
    req_data = 32'h4400_0033;
    req = 4'b1001;
    for (int c = 0; c < 20 && !Tx_Busy; c++) tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_first_grant: got %b want 0001", grant); end
    tick();
    Reset = 1'b1;
    tick();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL mid_reset_grant: got %b want 0000", grant); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL mid_reset_ack: got %b want 0000", ack); end
    total++; if (Tx_Data !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got %h want 00", Tx_Data); end
    total++; if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", Tx_Data_valid); end
    Reset = 1'b0;
    tick();
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_regrant: got %b want 0001", grant); end
    total++; if (Tx_Data !== 8'h33) begin bad++; $display("FAIL mid_regrant_data: got %h want 33", Tx_Data); end
    for (int c = 0; c < 40 && seen == 0; c++) begin
      tick();
      if (ack !== 4'b0) begin seen = 1; req = 4'b0; end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL mid_drain_ack: got %0d want 1", seen); end
    req = 4'b0;
    repeat (6) tick();
    $display("reset mid-frame: regrant ok");
  endtask

  task automatic test_busy_high();
    model_en = 1'b0;
    repeat (4) tick();
    Tx_Busy = 1'b0;
    do_reset();
    req_data = 32'h0000_005A;
    Tx_Busy = 1'b1;
    req = 4'b0001;
    tick();
    total++; if (Tx_Data_valid !== 1'b1) begin bad++; $display("FAIL bh_valid: got %b want 1", Tx_Data_valid); end
    tick();
    total++; if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL bh_valid_drop: got %b want 0", Tx_Data_valid); end
    tick();
    total++; if (Tx_Data_valid !== 1'b0) begin bad++; $display("FAIL bh_no_extra_valid: got %b want 0", Tx_Data_valid); end
    total++; if (ack !== 4'b0) begin bad++; $display("FAIL bh_early_ack: got %b want 0000", ack); end
    Tx_Busy = 1'b0;
    tick();
    total++; if (ack !== 4'b0001) begin bad++; $display("FAIL bh_ack: got %b want 0001", ack); end
    req = 4'b0;
    tick();
    tick();
    total++; if (grant !== 4'b0) begin bad++; $display("FAIL bh_idle_grant: got %b want 0000", grant); end
    $display("busy already high: frame acked");
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n, seen;
    logic [3:0] ack_val;
    n = -1; seen = 0; ack_val = '0;
    model_en = 1'b0;
    Tx_Busy  = 1'b0;
    do_reset();
    req_data = 32'h0000_6655;
    req = 4'b0011;
    tick();
    tick();
    for (int c = 1; c <= 100 && seen == 0; c++) begin
      tick();
      if (ack !== 4'b0) begin seen = 1; n = c; ack_val = ack; req = 4'b0010; end
    end
    total++; if (n !== 64) begin bad++; $display("FAIL to_latency: got %0d want 64", n); end
    total++; if (ack_val !== 4'b0001) begin bad++; $display("FAIL to_ack: got %b want 0001", ack_val); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err_timeout); end
    tick();
    tick();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL to_next_grant: got %b want 0010", grant); end
    total++; if (Tx_Data !== 8'h66) begin bad++; $display("FAIL to_next_data: got %h want 66", Tx_Data); end
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      tick();
      if (ack !== 4'b0) begin seen = 1; req = 4'b0; end
    end
    tick();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", err_timeout); end
    $display("timeout: ack after %0d cycles", n);
  endtask
`endif

  initial begin
    Reset    = 1'b1;
    req      = '0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
    test_busy_high();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
